// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants and types for the vector memory responder
package vmem_pkg;
  localparam int VMEM_DATA_W = 256;
  localparam int LINE_BYTES = VMEM_DATA_W / 8;
  localparam int WORDS_PER_LINE = 8;
  typedef logic [VMEM_DATA_W-1:0] line_t;
  typedef logic [LINE_BYTES-1:0] be_t;
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
endpackage

// File: rtl/vmem_array.sv
// vmem_array: single-port byte-enabled synchronous RAM, read-before-write
module vmem_array #(
  parameter int DEPTH = 4096,
  parameter int DATA_W = 256
) (
  input  logic                       clk,
  input  logic                       re,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // registered read sees the old line; byte lanes commit independently
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
    for (int i = 0; i < DATA_W / 8; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/vector_mem_responder.sv
// vector_mem_responder: processor/host/clear arbitration onto the vector data RAM
module vector_mem_responder
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 256,
  parameter int DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address_RAM,
  input  logic [DATA_W/8-1:0]   byteena_RAM,
  input  logic [DATA_W-1:0]     writeData_RAM,
  input  logic                  rden_RAM,
  input  logic                  wren_RAM,
  output logic [DATA_W-1:0]     readData_RAM,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_W+2:0]     host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  oor_err
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  clr_state_t state;
  logic [CW-1:0] cnt;
  logic proc_act, h_rd, clr_we, oor, arr_re, arr_we;
  logic p_rd_q, h_rd_q, oor_q;
  logic [2:0] h_word_q;
  logic [ADDR_W-1:0] arr_addr;
  logic [NB-1:0] arr_be;
  logic [DATA_W-1:0] arr_wdata, arr_rdata, p_hold;
  logic [31:0] h_hold;
  assign proc_act = rden_RAM | wren_RAM;
  assign host_gnt = reset & host_req & ~proc_act & (state == CLR_IDLE);
  assign h_rd = host_gnt & ~host_we;
  assign clr_we = (state == CLR_RUN) & ~proc_act;
  assign arr_addr = proc_act ? address_RAM : host_gnt ? host_addr[ADDR_W+2:3] : ADDR_W'(cnt);
  assign oor = 32'(arr_addr) >= DEPTH;
  assign arr_re = rden_RAM | h_rd;
  assign arr_we = ~oor & (wren_RAM | (host_gnt & host_we) | clr_we);
  assign arr_be = proc_act ? byteena_RAM : host_gnt ? NB'(4'hF) << {host_addr[2:0], 2'b00} : '1;
  assign arr_wdata = proc_act ? writeData_RAM : host_gnt ? {WORDS_PER_LINE{host_wdata}} : '0;
  // the RAM output register is shared, so each requester keeps its own copy between reads
  assign readData_RAM = p_rd_q ? (oor_q ? '0 : arr_rdata) : p_hold;
  assign host_rdata = h_rd_q ? (oor_q ? '0 : arr_rdata[32*h_word_q +: 32]) : h_hold;
  assign host_rvalid = h_rd_q;
  vmem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk(clk),
    .re(arr_re),
    .we(arr_we),
    .addr(arr_addr[AW-1:0]),
    .be(arr_be),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );
  // track which requester the last RAM read belongs to, hold read data, latch range errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_rd_q <= 1'b0;
      h_rd_q <= 1'b0;
      oor_q <= 1'b0;
      h_word_q <= '0;
      p_hold <= '0;
      h_hold <= '0;
      oor_err <= 1'b0;
    end else begin
      p_rd_q <= rden_RAM;
      h_rd_q <= h_rd;
      oor_q <= oor;
      h_word_q <= host_addr[2:0];
      p_hold <= readData_RAM;
      h_hold <= host_rdata;
      oor_err <= oor_err | (oor & (proc_act | host_gnt));
    end
  end
  // bulk clear: walk every line once, yielding to processor strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLR_IDLE;
      cnt <= '0;
      clr_busy <= 1'b0;
    end else if (state == CLR_IDLE && clr_start) begin
      state <= CLR_RUN;
      cnt <= '0;
      clr_busy <= 1'b1;
    end else if (clr_we) begin
      cnt <= cnt + 1'b1;
      state <= (cnt == CW'(DEPTH - 1)) ? CLR_IDLE : CLR_RUN;
      clr_busy <= cnt != CW'(DEPTH - 1);
    end
  end
endmodule

// File: tb/tb_vector_mem_responder.sv
// tb_vector_mem_responder: scoreboard bench for the vector memory responder
module tb_vector_mem_responder;
  localparam int AW = 14;
  localparam int DW = 256;
  localparam int D = 16;
  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] address_RAM;
  logic [DW/8-1:0] byteena_RAM;
  logic [DW-1:0] writeData_RAM;
  logic rden_RAM, wren_RAM;
  logic [DW-1:0] readData_RAM;
  logic host_req, host_we;
  logic [AW+2:0] host_addr;
  logic [31:0] host_wdata;
  logic host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic clr_start, clr_busy, oor_err;
  logic [DW-1:0] model [D];
  logic [DW-1:0] pq [$];
  logic [31:0] hq [$];
  int checks = 0;
  int errors = 0;
  logic p_chk;

  vector_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .address_RAM(address_RAM), .byteena_RAM(byteena_RAM), .writeData_RAM(writeData_RAM),
    .rden_RAM(rden_RAM), .wren_RAM(wren_RAM), .readData_RAM(readData_RAM),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .oor_err(oor_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) p_chk <= 1'b0;
    else p_chk <= rden_RAM;

  always @(negedge clk)
    if (p_chk) begin
      logic [DW-1:0] exp;
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL proc_read unexpected read data %h", readData_RAM);
      end else begin
        exp = pq.pop_front();
        if (readData_RAM !== exp) begin
          errors++;
          $display("FAIL proc_read got %h exp %h", readData_RAM, exp);
        end
      end
    end

  function automatic logic [DW-1:0] mread(input int a);
    return (a < D) ? model[a] : '0;
  endfunction

  task automatic proc(input bit rd, input bit wr, input int a, input logic [31:0] be, input logic [DW-1:0] d);
    rden_RAM = rd;
    wren_RAM = wr;
    address_RAM = a[AW-1:0];
    byteena_RAM = be;
    writeData_RAM = d;
    if (rd) pq.push_back(mread(a));
    if (wr && a < D)
      for (int i = 0; i < 32; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    rden_RAM = 1'b0;
    wren_RAM = 1'b0;
  endtask

  task automatic host(input bit we, input logic [AW+2:0] a, input logic [31:0] d);
    int n = 0;
    int line;
    logic [31:0] exp;
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    #1;
    while (!host_gnt && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!host_gnt) begin
      errors++;
      $display("FAIL host_gnt_timeout got %b exp 1", host_gnt);
    end
    line = int'(a[AW+2:3]);
    if (we && line < D) model[line][32*a[2:0] +: 32] = d;
    if (!we) hq.push_back(line < D ? model[line][32*a[2:0] +: 32] : 32'h0);
    @(negedge clk);
    host_req = 1'b0;
    if (!we) begin
      exp = hq.pop_front();
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
        errors++;
        $display("FAIL host_read rvalid %b data %h exp 1 %h", host_rvalid, host_rdata, exp);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (readData_RAM !== '0 || host_gnt !== 1'b0 || host_rvalid !== 1'b0 || host_rdata !== 32'h0 || clr_busy !== 1'b0 || oor_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs rd %h gnt %b rv %b hd %h busy %b oor %b exp all 0", readData_RAM, host_gnt, host_rvalid, host_rdata, clr_busy, oor_err);
    end
  endtask

  task automatic test_proc;
    proc(0, 1, 5, 32'hFFFF_FFFF, {8{32'hA5A5_0001}});
    proc(1, 0, 5, 0, '0);
    checks++;
    if (readData_RAM !== {8{32'hA5A5_0001}}) begin
      errors++;
      $display("FAIL proc_latency got %h exp %h", readData_RAM, {8{32'hA5A5_0001}});
    end
    proc(0, 1, 7, 32'hFFFF_FFFF, '1);
    proc(0, 1, 7, 32'h0000_000F, '0);
    proc(1, 0, 7, 0, '0);
    checks++;
    if (readData_RAM !== {{224{1'b1}}, 32'h0}) begin
      errors++;
      $display("FAIL proc_byteena got %h exp %h", readData_RAM, {{224{1'b1}}, 32'h0});
    end
    proc(1, 1, 5, 32'hFFFF_FFFF, {8{32'h1234_5678}});
    proc(1, 0, 5, 0, '0);
  endtask

  task automatic test_host;
    rden_RAM = 1'b1;
    address_RAM = 7;
    pq.push_back(model[7]);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 17'h3B;
    host_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL host_gnt_blocked got %b exp 0", host_gnt);
    end
    @(negedge clk);
    rden_RAM = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b1) begin
      errors++;
      $display("FAIL host_gnt_idle got %b exp 1", host_gnt);
    end
    model[7][127:96] = 32'hDEAD_BEEF;
    @(negedge clk);
    host_req = 1'b0;
    proc(1, 0, 7, 0, '0);
    checks++;
    if (readData_RAM[127:96] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL host_word_lane got %h exp %h", readData_RAM[127:96], 32'hDEAD_BEEF);
    end
    host(0, 17'h3B, 0);
    checks++;
    if (readData_RAM !== model[7]) begin
      errors++;
      $display("FAIL proc_hold got %h exp %h", readData_RAM, model[7]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      host_req = 1'b1;
      host_we = 1'b1;
      host_addr = {14'd2, 3'(i)};
      host_wdata = 32'hC0DE_0000 + 32'(i * 17);
      #1;
      checks++;
      if (host_gnt !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr_gnt got %b exp 1", host_gnt);
      end
      model[2][32*i +: 32] = host_wdata;
      @(negedge clk);
    end
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        exp = hq.pop_front();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== exp) begin
          errors++;
          $display("FAIL b2b_read rvalid %b data %h exp 1 %h", host_rvalid, host_rdata, exp);
        end
      end
      host_req = (i < 8);
      host_we = 1'b0;
      host_addr = {14'd2, 3'(7 - i)};
      if (i < 8) hq.push_back(model[2][32*(7-i) +: 32]);
      @(negedge clk);
    end
    checks++;
    if (host_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rvalid_pulse got %b exp 0", host_rvalid);
    end
  endtask

  task automatic test_clear;
    int busy = 0;
    int stalls = 0;
    for (int i = 0; i < D; i++) proc(0, 1, i, 32'hFFFF_FFFF, {8{32'(i) ^ 32'h5A5A_0000}});
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    while (clr_busy && busy < 100) begin
      busy++;
      wren_RAM = (busy % 4 == 0);
      address_RAM = 0;
      byteena_RAM = '0;
      if (wren_RAM) stalls++;
      if (busy == 3) clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
    end
    wren_RAM = 1'b0;
    checks++;
    if (busy !== D + stalls) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d exp %0d", busy, D + stalls);
    end
    for (int i = 0; i < D; i++) model[i] = '0;
    for (int i = 0; i < D; i++) proc(1, 0, i, 0, '0);
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_restart got %b exp 0", clr_busy);
    end
  endtask

  task automatic test_oor;
    checks++;
    if (oor_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_initial got %b exp 0", oor_err);
    end
    proc(0, 1, 0, 32'hFFFF_FFFF, {8{32'h0BAD_F00D}});
    proc(0, 1, D, 32'hFFFF_FFFF, '1);
    checks++;
    if (oor_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_set got %b exp 1", oor_err);
    end
    proc(0, 1, 4096, 32'hFFFF_FFFF, '1);
    proc(1, 0, D, 0, '0);
    proc(1, 0, 4096, 0, '0);
    proc(1, 0, 0, 0, '0);
    host(1, {14'd4096, 3'd1}, 32'hFFFF_FFFF);
    host(0, {14'd4096, 3'd1}, 0);
    host(0, {14'd0, 3'd1}, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (oor_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky got %b exp 1", oor_err);
    end
  endtask

  task automatic test_reset_abort;
    for (int i = 0; i < D; i++) proc(0, 1, i, 32'hFFFF_FFFF, {8{32'hE000_0000 | 32'(i)}});
    proc(1, 0, 3, 0, '0);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || readData_RAM !== '0 || oor_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset busy %b rd %h oor %b exp 0 0 0", clr_busy, readData_RAM, oor_err);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < D; i++) proc(1, 0, i, 0, '0);
  endtask

  initial begin
    reset = 1'b0;
    rden_RAM = 0; wren_RAM = 0; address_RAM = 0; byteena_RAM = 0; writeData_RAM = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; clr_start = 0;
    for (int i = 0; i < D; i++) model[i] = 'x;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b1;
    @(negedge clk);
    test_proc;
    test_host;
    test_back_to_back;
    test_clear;
    test_oor;
    test_reset_abort;
    repeat (2) @(negedge clk);
    checks++;
    if (pq.size() != 0 || hq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d %0d exp 0 0", pq.size(), hq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_mem_responder.md
Name: vector_mem_responder

Overview:
- Memory-side responder for the SIMD processor's vector data-RAM port (address_RAM, byteena_RAM, readData_RAM, writeData_RAM, rden_RAM, wren_RAM).
- Holds the 256-bit-line data store and answers processor reads and writes with fixed latency.
- Adds a 32-bit host port, used for image load and dump, and a bulk-clear engine.
- Sits beside simd_processor at the top level, in place of a vendor RAM macro.

Parameters:
- ADDR_W, 14, line address width (matches address_RAM).
- DATA_W, 256, line width in bits; byte enables are DATA_W/8.
- DEPTH, 4096, implemented lines; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- address_RAM  in  ADDR_W  processor line address
- byteena_RAM  in  DATA_W/8  processor byte enables; bit i covers data[8i+7:8i]
- writeData_RAM  in  DATA_W  processor write data
- rden_RAM  in  1  processor read strobe
- wren_RAM  in  1  processor write strobe
- readData_RAM  out  DATA_W  processor read data
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W+3  host 32-bit word address; [2:0] selects the word in the line
- host_wdata  in  32  host write word
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid, 1-cycle pulse
- host_rdata  out  32  host read word
- clr_start  in  1  pulse to start zeroing all lines
- clr_busy  out  1  clear in progress
- oor_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset, asynchronous on the falling edge of reset: every output goes to 0 and the clear FSM goes to IDLE. Array contents are not reset.
- Processor port has absolute priority and a fixed latency of 1:
  - If rden_RAM is high at edge N, readData_RAM holds the line from edge N+1 and keeps it until the next processor read.
  - Writes commit at the edge where wren_RAM is high, only to bytes with byteena_RAM set.
  - rden_RAM and wren_RAM together at the same address: readData_RAM returns the pre-write (old) data.
- Host port:
  - host_gnt = host_req AND no processor strobe AND clear FSM in IDLE. It is combinational; the host holds its request until it sees gnt.
  - A granted write updates a single 32-bit word using a 4-byte enable mask at byte offset 4*host_addr[2:0]. Other bytes are untouched.
  - A granted read asserts host_rvalid one cycle later, with host_rdata = the selected word. host_rdata holds between reads.
  - The host may issue back-to-back granted requests every cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start: clr_busy = 1 and the internal line counter = 0.
  - In CLEAR, when no processor strobe is active, write all-zero to the counter line and increment the counter. A processor strobe stalls the counter for that cycle.
  - After writing line DEPTH-1, go to IDLE and clear clr_busy on the following edge.
  - clr_start while busy is ignored.
  - Reset mid-clear aborts to IDLE; lines already cleared stay zero.
- Out of range (line address >= DEPTH, processor or host):
  - Writes are dropped.
  - Reads return 0 with normal latency and normal rvalid.
  - oor_err is set and stays set until reset.
- Arithmetic:
  - Host line index = host_addr[ADDR_W+2:3].
  - The clear counter is log2(DEPTH)+1 bits wide and has no wrap-around.
  - Addresses are unsigned.

Decomposition:
- Shared package vmem_pkg holds:
  - constants LINE_BYTES = DATA_W/8 and WORDS_PER_LINE = 8;
  - typedef line_t (logic [DATA_W-1:0]) and typedef be_t (logic [LINE_BYTES-1:0]);
  - enum clr_state_t {CLR_IDLE, CLR_RUN}.
- One sub-module, vmem_array: a single-port byte-enabled DEPTH x DATA_W synchronous RAM with read-before-write.
- vector_mem_responder muxes the three requesters (processor, host, clear) onto vmem_array and owns the FSM, grant logic, word select and error flag.

Test Plan:
- Reset, then processor write at addr 5 with byteena = 32'hFFFFFFFF and data = {8{32'hA5A5_0001}}, then rden at 5 -> readData_RAM = written line exactly 1 cycle after the read strobe.
- Processor write at addr 7 with byteena = 32'h0000000F over a line of all-ones, data = 0 -> read returns the line with bits [31:0] = 0 and the rest 1.
- Host write word address 0x3B (line 7, word 3) with 32'hDEADBEEF while rden_RAM is high -> host_gnt = 0 that cycle and 1 on the next idle cycle. A processor read of line 7 then shows bits [127:96] = 32'hDEADBEEF. A host read of 0x3B gives host_rvalid with host_rdata = 32'hDEADBEEF.
- clr_start with DEPTH = 16 and a processor strobe injected every 4th cycle -> clr_busy high for 16 + (number of stalled cycles) cycles. All 16 lines then read 0.
- Processor access to address 4096 with DEPTH = 4096 -> write dropped, read returns 0, oor_err = 1 and stays set until reset.
- Assert reset low during CLEAR at counter = 8 -> clr_busy = 0 and readData_RAM = 0 immediately. Lines 0-7 read 0; lines 8-15 keep their prior data.
